uart_wb_master: RTL and testbench

- UART-to-Wishbone debug bridge. It receives command frames on a UART RX line, issues single Wishbone master cycles, and returns responses on a UART TX line.
- It is the initiator-side counterpart to UART/Wishbone slave peripherals such as uart_dev.
- It lets a host PC, or a bench, peek and poke any Wishbone address on the SoC bus.

---
 rtl/uart_wb_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug bridge: 'W'/'R' command frames on RX drive single
// Wishbone master cycles; ACK, NAK or read data is returned on TX.
module uart_wb_master #(
    parameter int unsigned CLKS_PER_BIT = 48,
    parameter int unsigned WB_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    input  logic        wb_ack,
    output logic        busy
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TW = $clog2(WB_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(WB_TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // ---------------- RX path ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic [1:0]    rxd_sync;
    logic          rxd_s;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;

    assign rxd_s = rxd_sync[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_sync <= 2'b11;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rxd_sync <= {rxd_sync[0], uart_rxd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (!rxd_s) rx_state <= R_START;
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                        if (rxd_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- Command parser and Wishbone cycle ----------------
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_WB, P_TX} p_state_t;

    p_state_t      p_state;
    logic [1:0]    p_cnt;
    logic          cmd_we;
    logic [TW-1:0] tmo_cnt;
    logic          tx_start;
    logic [31:0]   tx_word;
    logic [1:0]    tx_extra;
    logic          tx_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_state  <= P_CMD;
            p_cnt    <= '0;
            cmd_we   <= 1'b0;
            tmo_cnt  <= '0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_dout  <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_word  <= '0;
            tx_extra <= '0;
        end else begin
            tx_start <= 1'b0;
            case (p_state)
                P_CMD: begin
                    if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
                        cmd_we  <= (rx_byte == CMD_WRITE);
                        busy    <= 1'b1;
                        p_cnt   <= '0;
                        p_state <= P_ADDR;
                    end
                end
                P_ADDR: begin
                    if (rx_ferr) begin
                        busy    <= 1'b0;
                        p_state <= P_CMD;
                    end else if (rx_valid) begin
                        wb_addr <= {rx_byte, wb_addr[31:8]};
                        p_cnt   <= p_cnt + 1'b1;
                        if (p_cnt == 2'd3) begin
                            if (cmd_we) begin
                                p_state <= P_DATA;
                            end else begin
                                wb_stb  <= 1'b1;
                                wb_we   <= 1'b0;
                                tmo_cnt <= '0;
                                p_state <= P_WB;
                            end
                        end
                    end
                end
                P_DATA: begin
                    if (rx_ferr) begin
                        busy    <= 1'b0;
                        p_state <= P_CMD;
                    end else if (rx_valid) begin
                        wb_dout <= {rx_byte, wb_dout[31:8]};
                        p_cnt   <= p_cnt + 1'b1;
                        if (p_cnt == 2'd3) begin
                            wb_stb  <= 1'b1;
                            wb_we   <= 1'b1;
                            tmo_cnt <= '0;
                            p_state <= P_WB;
                        end
                    end
                end
                P_WB: begin
                    // Ack is tested before the timeout so a last-cycle ack still succeeds
                    if (wb_ack) begin
                        wb_stb   <= 1'b0;
                        wb_we    <= 1'b0;
                        tx_start <= 1'b1;
                        p_state  <= P_TX;
                        if (wb_we) begin
                            tx_word  <= {24'h0, RSP_ACK};
                            tx_extra <= 2'd0;
                        end else begin
                            tx_word  <= wb_din;
                            tx_extra <= 2'd3;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        wb_stb   <= 1'b0;
                        wb_we    <= 1'b0;
                        tx_start <= 1'b1;
                        tx_word  <= {24'h0, RSP_NAK};
                        tx_extra <= 2'd0;
                        p_state  <= P_TX;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                P_TX: begin
                    if (tx_done) begin
                        busy    <= 1'b0;
                        p_state <= P_CMD;
                    end
                end
                default: p_state <= P_CMD;
            endcase
        end
    end

    // ---------------- TX path ----------------
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;
    logic [23:0]   tx_rest;
    logic [1:0]    tx_left;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= T_IDLE;
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx_rest  <= '0;
            tx_left  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_start) begin
                        uart_txd <= 1'b0;
                        tx_shift <= {1'b1, tx_word[7:0]};
                        tx_rest  <= tx_word[31:8];
                        tx_left  <= tx_extra;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (tx_cnt != BIT_LAST) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit != 4'd9) begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end else if (tx_left != 2'd0) begin
                            // Next byte's start bit follows the stop bit directly
                            uart_txd <= 1'b0;
                            tx_shift <= {1'b1, tx_rest[7:0]};
                            tx_rest  <= {8'h00, tx_rest[23:8]};
                            tx_left  <= tx_left - 1'b1;
                            tx_bit   <= '0;
                        end else begin
                            uart_txd <= 1'b1;
                            tx_done  <= 1'b1;
                            tx_state <= T_IDLE;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: UART host driver, Wishbone slave, TX decoder and a
// memory-level reference model of expected bus cycles and responses.
`timescale 1ns/1ps
module tb_uart_wb_master;
    localparam int CPB = 48;
    localparam int TMO = 1024;

    logic        clk, rst, uart_rxd, uart_txd;
    logic        wb_stb, wb_we, wb_ack, busy;
    logic [31:0] wb_addr, wb_dout, wb_din;

    uart_wb_master #(.CLKS_PER_BIT(CPB), .WB_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr), .wb_dout(wb_dout),
        .wb_din(wb_din), .wb_ack(wb_ack), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wishbone slave: acks ack_delay cycles into the strobe (0 = never)
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    int          ack_delay = 3;
    bit          spur_ack  = 0;
    bit          in_cyc    = 0;
    int          stb_len = 0, txn_count = 0, wb_unstable = 0, stb_fall_cyc = 0;
    logic        txn_we;
    logic [31:0] txn_addr, txn_dout;

    initial begin
        wb_ack = 1'b0;
        wb_din = '0;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            wb_din = $urandom;
            if (wb_stb === 1'b1) begin
                if (!in_cyc) begin
                    in_cyc = 1; stb_len = 0; txn_count++;
                    txn_we = wb_we; txn_addr = wb_addr; txn_dout = wb_dout;
                end else if (wb_we !== txn_we || wb_addr !== txn_addr || wb_dout !== txn_dout) begin
                    wb_unstable++;
                end
                stb_len++;
                if (ack_delay > 0 && stb_len == ack_delay) begin
                    wb_ack = 1'b1;
                    if (txn_we) slave_mem[txn_addr] = txn_dout;
                    else wb_din = slave_mem.exists(txn_addr) ? slave_mem[txn_addr] : ~txn_addr;
                end
            end else begin
                if (in_cyc) begin
                    in_cyc = 0;
                    stb_fall_cyc = cyc;
                end
                if (spur_ack) wb_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    int   busy_rises = 0, busy_fall_cyc = 0;
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1 && !busy_q) busy_rises <= busy_rises + 1;
        if (busy === 1'b0 && busy_q) busy_fall_cyc <= cyc;
        busy_q <= (busy === 1'b1);
    end

    // TX decoder: samples mid-bit, records each frame's start cycle
    logic [7:0] tx_q[$];
    int         tx_t[$];
    int         tx_bad_stop = 0;
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_txd === 1'b0) begin
                t0 = cyc;
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                if (uart_txd !== 1'b1) tx_bad_stop++;
                tx_q.push_back(b);
                tx_t.push_back(t0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data);
        send_byte(we ? 8'h57 : 8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
        if (we) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
    endtask

    task automatic do_cmd(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input int dly, input bit overlap);
        logic [7:0]  exp_q[$];
        logic [31:0] v;
        bit          tmo;
        int          base_txn, base_rises, t, d;
        tmo = (dly < 1) || (dly > TMO);
        if (tmo) begin
            exp_q.push_back(8'h15);
        end else if (we) begin
            exp_q.push_back(8'h06);
            ref_mem[addr] = data;
        end else begin
            v = ref_mem.exists(addr) ? ref_mem[addr] : ~addr;
            for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
        end
        ack_delay = dly;
        tx_q.delete(); tx_t.delete();
        tx_bad_stop = 0; wb_unstable = 0;
        base_txn = txn_count; base_rises = busy_rises;
        send_cmd(we, addr, data);
        if (overlap) begin
            t = 0;
            while (tx_q.size() == 0 && t < 4000) begin @(negedge clk); t++; end
            send_byte(8'h57, 1'b1);
        end
        t = 0;
        while (busy !== 1'b0 && t < 6000) begin @(negedge clk); t++; end
        check({tag, "/busy_done"}, 32'(busy), 32'd0);
        repeat (CPB) @(negedge clk);
        check({tag, "/txns"}, 32'(txn_count - base_txn), 32'd1);
        check({tag, "/busy_rises"}, 32'(busy_rises - base_rises), 32'd1);
        check({tag, "/we"}, 32'(txn_we), 32'(we));
        check({tag, "/addr"}, txn_addr, addr);
        if (we) check({tag, "/dout"}, txn_dout, data);
        check({tag, "/stb_len"}, 32'(stb_len), tmo ? 32'(TMO) : 32'(dly));
        check({tag, "/stable"}, 32'(wb_unstable), 32'd0);
        check({tag, "/nbytes"}, 32'(tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < tx_q.size()) check($sformatf("%s/byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
        check({tag, "/stop_bits"}, 32'(tx_bad_stop), 32'd0);
        if (tx_t.size() > 0) begin
            d = tx_t[0] - stb_fall_cyc;
            check({tag, "/start_lat_le2"}, 32'(d >= 0 && d <= 2), 32'd1);
            for (int i = 1; i < tx_t.size(); i++)
                check($sformatf("%s/gap%0d", tag, i), 32'(tx_t[i] - tx_t[i-1]), 32'(10*CPB));
            check({tag, "/busy_fall"}, 32'(busy_fall_cyc - tx_t[tx_t.size()-1]), 32'(10*CPB + 1));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, base_txn, base_rises;
        logic        r_we;
        logic [31:0] r_addr, r_data;
        int          r_dly;
        logic [31:0] pool [4];

        rst = 1'b0;
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("reset/txd",  32'(uart_txd), 32'd1);
        check("reset/stb",  32'(wb_stb),   32'd0);
        check("reset/we",   32'(wb_we),    32'd0);
        check("reset/addr", wb_addr,       32'd0);
        check("reset/dout", wb_dout,       32'd0);
        check("reset/busy", 32'(busy),     32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        slave_mem[32'h8] = 32'hDEADBEEF;
        ref_mem[32'h8]   = 32'hDEADBEEF;
        do_cmd("t1_write", 1'b1, 32'h0000_0400, 32'h0123_4567, 3, 1'b0);
        do_cmd("t2_read_overlap", 1'b0, 32'h0000_0008, 32'h0, 2, 1'b1);
        do_cmd("t3_timeout", 1'b0, 32'h1000_0000, 32'h0, 0, 1'b0);
        do_cmd("ack_at_timeout", 1'b0, 32'h0000_0400, 32'h0, TMO, 1'b0);

        // Noise: non-command bytes, framing error, short glitch, stray acks
        spur_ack = 1;
        base_txn = txn_count; base_rises = busy_rises;
        tx_q.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h57, 1'b0);
        repeat (2*CPB) @(negedge clk);
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("noise/txns", 32'(txn_count - base_txn), 32'd0);
        check("noise/busy_rises", 32'(busy_rises - base_rises), 32'd0);
        check("noise/tx_bytes", 32'(tx_q.size()), 32'd0);
        do_cmd("t4_write_after_noise", 1'b1, 32'h0000_0020, $urandom, 5, 1'b0);

        pool[0] = 32'h0000_0400; pool[1] = 32'h0000_0008;
        pool[2] = 32'h0000_0020; pool[3] = $urandom & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = pool[$urandom_range(0, 3)];
            r_data = $urandom;
            r_dly  = $urandom_range(1, 6);
            do_cmd($sformatf("rand%0d", k), r_we, r_addr, r_data, r_dly, 1'b0);
        end
        spur_ack = 0;

        // Reset in the middle of the third address byte
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = 1'($urandom_range(0, 1));
            repeat (CPB) @(negedge clk);
        end
        check("rst1/busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst1/stb",  32'(wb_stb),   32'd0);
        check("rst1/txd",  32'(uart_txd), 32'd1);
        check("rst1/busy", 32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (2*CPB) @(negedge clk);
        do_cmd("rst1_read", 1'b0, 32'h0000_0400, 32'h0, 2, 1'b0);

        // Reset while the strobe is waiting for an ack
        ack_delay = 0;
        tx_q.delete();
        send_cmd(1'b0, 32'h0000_0040, 32'h0);
        t = 0;
        while (wb_stb !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("rst2/stb_before", 32'(wb_stb), 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst2/stb",  32'(wb_stb),   32'd0);
        check("rst2/txd",  32'(uart_txd), 32'd1);
        check("rst2/busy", 32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("rst2/no_response", 32'(tx_q.size()), 32'd0);
        do_cmd("rst2_read", 1'b0, 32'h0000_0008, 32'h0, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
